// File: rtl/servo_pwm_reader_if.sv
// Register-access bus between the processor's I/O decode and servo_pwm_reader.
//   master : processor side, drives writes and the readback address
//   slave  : servo_pwm_reader side, returns the registered readback data
// Signals:
//   wr_en    write strobe for the shadow register at wr_addr
//   wr_addr  channel index to write (out-of-range indices are ignored)
//   wr_data  8-bit joint angle to write
//   rd_addr  channel index for shadow readback (out of range reads as 0)
//   rd_data  shadow[rd_addr], registered, one cycle after rd_addr
// There is no valid/ready pair on this bus: a write is accepted on every
// rising clk edge where wr_en is high, and readback is continuous with a
// fixed one-cycle latency, so the master never has to wait.
interface servo_pwm_reader_if;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output rd_addr,
    input  rd_data
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  rd_addr,
    output rd_data
  );
endinterface

// File: rtl/servo_pwm_reader.sv
// Servo joint-command reader: shadow registers written by the processor are
// copied into active registers at each frame boundary, and every channel gets
// one PWM pulse per frame whose width follows its active angle.
// Ports:
//   clk          clock, rising edge
//   clr          asynchronous active-high reset
//   arm_en       1 = PWM outputs enabled, 0 = all pwm held low
//   bus          register bus (slave side): wr_en/wr_addr/wr_data/rd_addr in,
//                rd_data out
//   pwm          servo pulse outputs, bit i = channel i
//   frame_start  high for the one cycle in which the frame counter is 0
module servo_pwm_reader #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned FRAME_TICKS = 1000000,
  parameter int unsigned MIN_TICKS   = 50000,
  parameter int unsigned STEP_TICKS  = 196,
  parameter int unsigned RESET_ANGLE = 128
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  arm_en,
  servo_pwm_reader_if.slave     bus,
  output logic [NUM_CH-1:0]     pwm,
  output logic                  frame_start
);

  localparam logic [31:0] LAST_COUNT = 32'(FRAME_TICKS - 1);
  localparam logic [31:0] MIN_W      = 32'(MIN_TICKS);
  localparam logic [31:0] STEP_W     = 32'(STEP_TICKS);
  localparam logic [7:0]  RST_ANGLE  = 8'(RESET_ANGLE);

  logic [31:0]       count;
  logic [31:0]       count_next;
  logic              frame_last;
  logic [7:0]        shadow [NUM_CH];
  logic [7:0]        active [NUM_CH];
  logic [31:0]       width  [NUM_CH];
  logic [NUM_CH-1:0] pwm_next;
  logic [7:0]        rd_next;

  // Free-running frame counter; runs regardless of arm_en.
  always_comb begin
    frame_last = (count == LAST_COUNT);
    count_next = frame_last ? 32'd0 : count + 32'd1;
  end

  // Pulse widths, next PWM levels and readback mux, all from pre-edge state.
  // The readback mux only matches indices below NUM_CH, so out-of-range
  // addresses fall through to the default of 0.
  always_comb begin
    width    = '{default: 32'd0};
    pwm_next = '0;
    rd_next  = 8'd0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      width[i]    = MIN_W + 32'(active[i]) * STEP_W;
      pwm_next[i] = arm_en & (count < width[i]);
      if (bus.rd_addr == 4'(i)) begin
        rd_next = shadow[i];
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count       <= 32'd0;
      shadow      <= '{default: RST_ANGLE};
      active      <= '{default: RST_ANGLE};
      pwm         <= '0;
      bus.rd_data <= 8'd0;
      frame_start <= 1'b0;
    end else begin
      count       <= count_next;
      frame_start <= (count_next == 32'd0);
      pwm         <= pwm_next;
      // Readback samples shadow before this edge's write lands, so a
      // read/write to the same channel returns the old value.
      bus.rd_data <= rd_next;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        // Frame load sees the pre-edge shadow; a write on the same edge
        // only reaches active at the end of the following frame.
        if (frame_last) begin
          active[i] <= shadow[i];
        end
        // Address decode only matches real channels, so writes to
        // indices >= NUM_CH have no effect.
        if (bus.wr_en && (bus.wr_addr == 4'(i))) begin
          shadow[i] <= bus.wr_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_reader.sv
// Self-checking bench for servo_pwm_reader with a 400-cycle frame.
module tb_servo_pwm_reader;

  localparam int NCH  = 4;
  localparam int FT   = 400;
  localparam int MINT = 20;
  localparam int STEP = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic arm_en = 1'b0;
  logic [NCH-1:0] pwm;
  logic frame_start;

  always #5 clk = ~clk;

  servo_pwm_reader_if bus_if ();

  servo_pwm_reader #(
    .NUM_CH      (NCH),
    .FRAME_TICKS (FT),
    .MIN_TICKS   (MINT),
    .STEP_TICKS  (STEP),
    .RESET_ANGLE (128)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .arm_en      (arm_en),
    .bus         (bus_if),
    .pwm         (pwm),
    .frame_start (frame_start)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q [$];   // expected per-channel pulse widths, one frame
  logic [7:0]  rd_q  [$];   // expected rd_data for the next sampled edge
  int          model_cnt;
  logic [7:0]  m_shadow [NCH];
  logic [7:0]  m_active [NCH];
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic model_reset();
    model_cnt = 0;
    for (int c = 0; c < NCH; c++) begin
      m_shadow[c] = 8'd128;
      m_active[c] = 8'd128;
    end
  endtask

  // One clock: outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (!clr) begin
      if (model_cnt == FT - 1) begin
        for (int c = 0; c < NCH; c++) m_active[c] = m_shadow[c];
        model_cnt = 0;
      end else begin
        model_cnt++;
      end
    end
  endtask

  task automatic wait_count(input int n);
    for (int k = 0; k < FT; k++) begin
      if (model_cnt == n) break;
      step();
    end
  endtask

  // Runs one full frame starting at count 0. Optionally performs a write
  // (and reads the same address back) when the counter equals wr_at, and
  // drops/raises arm_en at counts off/on. Pulse widths are measured by
  // counting high samples over the frame.
  task automatic run_frame(input int wr_at, input logic [3:0] wa,
                           input logic [7:0] wd, input int off, input int on);
    int hi [NCH];
    int fs_bad;
    int pre;
    int cnt;
    int w;
    logic [31:0] exp_w;
    logic [7:0]  exp_rd;
    wait_count(0);
    for (int c = 0; c < NCH; c++) begin
      w   = MINT + int'(m_active[c]) * STEP;
      cnt = 0;
      for (int k = 0; k < FT; k++) begin
        if (k < w && !(k >= off && k < on)) cnt++;
      end
      exp_q.push_back(32'(cnt));
      hi[c] = 0;
    end
    fs_bad = 0;
    for (int it = 0; it < FT; it++) begin
      pre = model_cnt;
      if (pre == off) arm_en = 1'b0;
      if (pre == on)  arm_en = 1'b1;
      if (pre == wr_at) begin
        bus_if.wr_en   = 1'b1;
        bus_if.wr_addr = wa;
        bus_if.wr_data = wd;
        bus_if.rd_addr = wa;
        rd_q.push_back((wa < NCH) ? m_shadow[wa[1:0]] : 8'd0);
      end
      step();
      if (rd_q.size() != 0) begin
        exp_rd = rd_q.pop_front();
        n_total++;
        if (bus_if.rd_data !== exp_rd)
          $display("FAIL readback_addr%0d: got %0d expected %0d", bus_if.rd_addr, bus_if.rd_data, exp_rd);
        else n_pass++;
      end
      if (pre == wr_at) begin
        bus_if.wr_en = 1'b0;
        if (wa < NCH) m_shadow[wa[1:0]] = wd;
        rd_q.push_back((wa < NCH) ? m_shadow[wa[1:0]] : 8'd0);
      end
      for (int c = 0; c < NCH; c++) if (pwm[c] === 1'b1) hi[c]++;
      if (frame_start !== (model_cnt == 0)) fs_bad++;
    end
    for (int c = 0; c < NCH; c++) begin
      exp_w = exp_q.pop_front();
      n_total++;
      if (32'(hi[c]) !== exp_w)
        $display("FAIL width_ch%0d: got %0d cycles expected %0d", c, hi[c], exp_w);
      else n_pass++;
    end
    n_total++;
    if (fs_bad !== 0)
      $display("FAIL frame_start_timing: got %0d misplaced samples expected 0", fs_bad);
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus_if.wr_en   = 1'b0;
    bus_if.wr_addr = 4'd0;
    bus_if.wr_data = 8'd0;
    bus_if.rd_addr = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    clr    = 1'b0;
    arm_en = 1'b1;
    repeat (10) step();
    n_total++;
    if (bus_if.rd_data !== m_shadow[0])
      $display("FAIL pre_reset_readback: got %0d expected %0d", bus_if.rd_data, m_shadow[0]);
    else n_pass++;
    // Assert clr between clock edges; outputs must clear without an edge.
    #3;
    clr = 1'b1;
    #1;
    n_total++;
    if (pwm !== 4'b0000) $display("FAIL reset_pwm: got %b expected 0000", pwm);
    else n_pass++;
    n_total++;
    if (bus_if.rd_data !== 8'd0) $display("FAIL reset_rd_data: got %0d expected 0", bus_if.rd_data);
    else n_pass++;
    n_total++;
    if (frame_start !== 1'b0) $display("FAIL reset_frame_start: got %b expected 0", frame_start);
    else n_pass++;
    model_reset();
    step();
    n_total++;
    if (pwm !== 4'b0000) $display("FAIL reset_hold_pwm: got %b expected 0000", pwm);
    else n_pass++;
    clr = 1'b0;
    run_frame(-1, 4'd0, 8'd0, -1, -1);
  endtask

  task automatic test_write_mid();
    run_frame(100, 4'd2, 8'd255, -1, -1);
    run_frame(-1, 4'd0, 8'd0, -1, -1);
  endtask

  task automatic test_write_frame_edge();
    run_frame(FT - 1, 4'd0, 8'd0, -1, -1);
    run_frame(-1, 4'd0, 8'd0, -1, -1);
    run_frame(-1, 4'd0, 8'd0, -1, -1);
  endtask

  task automatic test_bad_addr();
    logic [7:0] exp_rd;
    run_frame(200, 4'd5, 8'd9, -1, -1);
    // Every real shadow register must still hold its earlier value.
    for (int c = 0; c < NCH; c++) begin
      bus_if.rd_addr = 4'(c);
      rd_q.push_back(m_shadow[c]);
      step();
      exp_rd = rd_q.pop_front();
      n_total++;
      if (bus_if.rd_data !== exp_rd)
        $display("FAIL shadow_after_bad_write_ch%0d: got %0d expected %0d", c, bus_if.rd_data, exp_rd);
      else n_pass++;
    end
  endtask

  task automatic test_arm_gate();
    run_frame(-1, 4'd0, 8'd0, 50, 60);
  endtask

  task automatic test_clr_mid_pulse();
    logic [NCH-1:0] exp_pwm;
    logic [7:0]     exp_rd;
    wait_count(98);
    bus_if.rd_addr = 4'd2;
    step();
    step();
    n_total++;
    if (bus_if.rd_data !== m_shadow[2])
      $display("FAIL pre_clr_readback: got %0d expected %0d", bus_if.rd_data, m_shadow[2]);
    else n_pass++;
    for (int c = 0; c < NCH; c++) exp_pwm[c] = (99 < MINT + int'(m_active[c]) * STEP);
    n_total++;
    if (pwm !== exp_pwm) $display("FAIL pre_clr_pwm: got %b expected %b", pwm, exp_pwm);
    else n_pass++;
    #2;
    clr = 1'b1;
    #1;
    n_total++;
    if (pwm !== 4'b0000) $display("FAIL clr_pwm: got %b expected 0000", pwm);
    else n_pass++;
    n_total++;
    if (bus_if.rd_data !== 8'd0) $display("FAIL clr_rd_data: got %0d expected 0", bus_if.rd_data);
    else n_pass++;
    n_total++;
    if (frame_start !== 1'b0) $display("FAIL clr_frame_start: got %b expected 0", frame_start);
    else n_pass++;
    model_reset();
    step();
    clr = 1'b0;
    run_frame(-1, 4'd0, 8'd0, -1, -1);
    rd_q.push_back(m_shadow[2]);
    step();
    exp_rd = rd_q.pop_front();
    n_total++;
    if (bus_if.rd_data !== exp_rd)
      $display("FAIL clr_restores_shadow: got %0d expected %0d", bus_if.rd_data, exp_rd);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_mid();
    test_write_frame_edge();
    test_bad_addr();
    test_arm_gate();
    test_clr_mid_pulse();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
